// File: rtl/i2c_passthru_stat.sv
// i2c_passthru_stat
// Status stage behind the I2C passthru core. It counts the core's event pulses
// (idle timeout, bit violation, cha/chb stuck) and the mastership grants of each
// channel. Counters are read through a 4-phase req/ack handshake, with optional
// clear-on-read.
// Optional feature: define I2C_PASSTHRU_STAT_IRQ_EN to build the violation-pending
// interrupt. Without it, o_irq is tied low.
//
// Read FSM states:
//   state   | meaning
//   IDLE    | waiting for i_rd_req; snapshots the selected counter when it arrives
//   ACK     | o_rd_ack is high for this single cycle
//   WAIT    | waiting for the master to drop i_rd_req
module i2c_passthru_stat #(
    parameter int WIDTH_CNT = 8,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_idle_timeout,
    input  logic                 i_bit_violation,
    input  logic                 i_cha_stuck,
    input  logic                 i_chb_stuck,
    input  logic                 i_cha_ismst,
    input  logic                 i_chb_ismst,
    input  logic                 i_rd_req,
    input  logic [2:0]           i_rd_sel,
    input  logic                 i_rd_clr,
    output logic                 o_rd_ack,
    output logic [WIDTH_CNT-1:0] o_rd_data,
    output logic                 o_irq
);

    localparam int NCNT = 6;
    localparam logic [WIDTH_CNT-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } rd_state_t;

    rd_state_t            state;
    logic [WIDTH_CNT-1:0] cnt     [NCNT];
    logic [WIDTH_CNT-1:0] cnt_nxt [NCNT];
    logic                 prev_cha;
    logic                 prev_chb;
    logic [NCNT-1:0]      ev;
    logic [NCNT-1:0]      clr_vec;
    logic                 rd_take;
    logic [WIDTH_CNT-1:0] rd_mux;

    // Event vector in counter-map order; grants are rising edges of the ismst levels.
    assign ev = {i_chb_ismst & ~prev_chb,
                 i_cha_ismst & ~prev_cha,
                 i_chb_stuck,
                 i_cha_stuck,
                 i_bit_violation,
                 i_idle_timeout};

    assign rd_take = (state == ST_IDLE) && i_rd_req;

    // Read mux: selects 6 and 7 have no storage and read as zero.
    always_comb begin
        rd_mux = '0;
        case (i_rd_sel)
            3'd0:    rd_mux = cnt[0];
            3'd1:    rd_mux = cnt[1];
            3'd2:    rd_mux = cnt[2];
            3'd3:    rd_mux = cnt[3];
            3'd4:    rd_mux = cnt[4];
            3'd5:    rd_mux = cnt[5];
            default: rd_mux = '0;
        endcase
    end

    // Clear strobe per counter; only a read accepted in IDLE can clear.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < NCNT; i++) begin
            clr_vec[i] = rd_take && i_rd_clr && (i_rd_sel == 3'(i));
        end
    end

    // Next counter values. A clear that coincides with an event leaves 1, so the
    // event is kept but is not part of the snapshot taken on that edge.
    always_comb begin
        for (int i = 0; i < NCNT; i++) begin
            cnt_nxt[i] = cnt[i];
            if (clr_vec[i]) begin
                cnt_nxt[i] = {{(WIDTH_CNT-1){1'b0}}, ev[i]};
            end else if (ev[i]) begin
                if (SATURATE && (cnt[i] == CNT_MAX)) begin
                    cnt_nxt[i] = cnt[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Counter and grant-edge registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < NCNT; i++) begin
                cnt[i] <= '0;
            end
            prev_cha <= 1'b0;
            prev_chb <= 1'b0;
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            prev_cha <= i_cha_ismst;
            prev_chb <= i_chb_ismst;
        end
    end

    // Read handshake FSM with registered ack and data.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= ST_IDLE;
            o_rd_ack  <= 1'b0;
            o_rd_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_rd_ack <= 1'b0;
                    if (i_rd_req) begin
                        o_rd_data <= rd_mux;
                        o_rd_ack  <= 1'b1;
                        state     <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    o_rd_ack <= 1'b0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    o_rd_ack <= 1'b0;
                    if (!i_rd_req) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    o_rd_ack <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef I2C_PASSTHRU_STAT_IRQ_EN
    logic viol_nxt;

    assign viol_nxt = (|cnt_nxt[0]) | (|cnt_nxt[1]) | (|cnt_nxt[2]) | (|cnt_nxt[3]);

    // Interrupt follows the post-update violation counters; grants never raise it.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_irq <= 1'b0;
        end else begin
            o_irq <= viol_nxt;
        end
    end
`else
    assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_passthru_stat.sv
// Bench for i2c_passthru_stat: three instances (W=8 saturating, W=2 saturating,
// W=2 wrapping) share one stimulus and are checked every cycle against a
// behavioural counter/handshake model, plus literal expectations from directed tests.
module tb_i2c_passthru_stat;

`ifdef I2C_PASSTHRU_STAT_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic i_clk, i_rstn;
    logic i_idle_timeout, i_bit_violation, i_cha_stuck, i_chb_stuck;
    logic i_cha_ismst, i_chb_ismst;
    logic i_rd_req, i_rd_clr;
    logic [2:0] i_rd_sel;

    logic       ack0, ack1, ack2;
    logic [7:0] data0;
    logic [1:0] data1, data2;
    logic       irq0, irq1, irq2;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_en  = 1'b0;
    bit  rnd_on  = 1'b0;

    i2c_passthru_stat #(.WIDTH_CNT(8), .SATURATE(1'b1)) u_dut0 (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_idle_timeout(i_idle_timeout), .i_bit_violation(i_bit_violation),
        .i_cha_stuck(i_cha_stuck), .i_chb_stuck(i_chb_stuck),
        .i_cha_ismst(i_cha_ismst), .i_chb_ismst(i_chb_ismst),
        .i_rd_req(i_rd_req), .i_rd_sel(i_rd_sel), .i_rd_clr(i_rd_clr),
        .o_rd_ack(ack0), .o_rd_data(data0), .o_irq(irq0));

    i2c_passthru_stat #(.WIDTH_CNT(2), .SATURATE(1'b1)) u_dut1 (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_idle_timeout(i_idle_timeout), .i_bit_violation(i_bit_violation),
        .i_cha_stuck(i_cha_stuck), .i_chb_stuck(i_chb_stuck),
        .i_cha_ismst(i_cha_ismst), .i_chb_ismst(i_chb_ismst),
        .i_rd_req(i_rd_req), .i_rd_sel(i_rd_sel), .i_rd_clr(i_rd_clr),
        .o_rd_ack(ack1), .o_rd_data(data1), .o_irq(irq1));

    i2c_passthru_stat #(.WIDTH_CNT(2), .SATURATE(1'b0)) u_dut2 (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_idle_timeout(i_idle_timeout), .i_bit_violation(i_bit_violation),
        .i_cha_stuck(i_cha_stuck), .i_chb_stuck(i_chb_stuck),
        .i_cha_ismst(i_cha_ismst), .i_chb_ismst(i_chb_ismst),
        .i_rd_req(i_rd_req), .i_rd_sel(i_rd_sel), .i_rd_clr(i_rd_clr),
        .o_rd_ack(ack2), .o_rd_data(data2), .o_irq(irq2));

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mcnt [3][6];
    int mmax [3] = '{255, 3, 3};
    bit msat [3] = '{1'b1, 1'b1, 1'b0};
    int m_data [3];
    bit m_ack, m_busy, m_pa, m_pb;
    bit m_irq [3];
    bit mev [6];
    bit mclr [6];

    always @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < 6; i++) mcnt[d][i] = 0;
                m_data[d] = 0;
                m_irq[d]  = 1'b0;
            end
            m_ack = 1'b0; m_busy = 1'b0; m_pa = 1'b0; m_pb = 1'b0;
        end else begin
            mev[0] = i_idle_timeout;
            mev[1] = i_bit_violation;
            mev[2] = i_cha_stuck;
            mev[3] = i_chb_stuck;
            mev[4] = i_cha_ismst && !m_pa;
            mev[5] = i_chb_ismst && !m_pb;
            for (int i = 0; i < 6; i++) mclr[i] = 1'b0;
            if (m_ack) begin
                m_ack = 1'b0;
            end else if (m_busy) begin
                if (!i_rd_req) m_busy = 1'b0;
            end else if (i_rd_req) begin
                for (int d = 0; d < 3; d++)
                    m_data[d] = (i_rd_sel < 3'd6) ? mcnt[d][i_rd_sel] : 0;
                if (i_rd_clr && i_rd_sel < 3'd6) mclr[i_rd_sel] = 1'b1;
                m_ack  = 1'b1;
                m_busy = 1'b1;
            end
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < 6; i++) begin
                    if (mclr[i])
                        mcnt[d][i] = mev[i] ? 1 : 0;
                    else if (mev[i])
                        mcnt[d][i] = msat[d] ? ((mcnt[d][i] < mmax[d]) ? mcnt[d][i] + 1 : mcnt[d][i])
                                             : ((mcnt[d][i] + 1) % (mmax[d] + 1));
                end
                m_irq[d] = IRQ_ON && (mcnt[d][0] + mcnt[d][1] + mcnt[d][2] + mcnt[d][3] != 0);
            end
            m_pa = i_cha_ismst;
            m_pb = i_chb_ismst;
        end
    end

    // Per-cycle compare of all outputs against the model.
    always @(negedge i_clk) begin
        if (chk_en) begin
            check("ack0", 32'(ack0), 32'(m_ack));
            check("ack1", 32'(ack1), 32'(m_ack));
            check("ack2", 32'(ack2), 32'(m_ack));
            check("data0", 32'(data0), m_data[0]);
            check("data1", 32'(data1), m_data[1]);
            check("data2", 32'(data2), m_data[2]);
            check("irq0", 32'(irq0), 32'(m_irq[0]));
            check("irq1", 32'(irq1), 32'(m_irq[1]));
            check("irq2", 32'(irq2), 32'(m_irq[2]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge i_clk);
        #2;
        if (rnd_on) begin
            i_idle_timeout  = ($urandom % 6) == 0;
            i_bit_violation = ($urandom % 6) == 0;
            i_cha_stuck     = ($urandom % 6) == 0;
            i_chb_stuck     = ($urandom % 6) == 0;
            if (($urandom % 8) == 0) i_cha_ismst = ~i_cha_ismst;
            if (($urandom % 8) == 0) i_chb_ismst = ~i_chb_ismst;
        end else begin
            i_idle_timeout = 1'b0; i_bit_violation = 1'b0;
            i_cha_stuck    = 1'b0; i_chb_stuck     = 1'b0;
        end
    endtask

    task automatic pulses(input int n, input int which);
        for (int k = 0; k < n; k++) begin
            case (which)
                0: i_idle_timeout  = 1'b1;
                1: i_bit_violation = 1'b1;
                2: i_cha_stuck     = 1'b1;
                default: i_chb_stuck = 1'b1;
            endcase
            cyc();
        end
    endtask

    // ev = {chb_stuck, cha_stuck, bit_violation, idle_timeout} driven on the request edge.
    task automatic do_read(input int sel, input bit clr, input logic [3:0] ev,
                           output int d0, output int d1, output int d2);
        int k;
        i_rd_sel = 3'(sel);
        i_rd_clr = clr;
        i_rd_req = 1'b1;
        i_idle_timeout  = i_idle_timeout  | ev[0];
        i_bit_violation = i_bit_violation | ev[1];
        i_cha_stuck     = i_cha_stuck     | ev[2];
        i_chb_stuck     = i_chb_stuck     | ev[3];
        cyc();
        k = 0;
        while (!ack0 && k < 8) begin
            cyc();
            k++;
        end
        check("rd_latency", 32'(k), 32'd0);
        d0 = 32'(data0); d1 = 32'(data1); d2 = 32'(data2);
        i_rd_req = 1'b0;
        i_rd_clr = 1'b0;
        cyc();
        cyc();
    endtask

    int r0, r1, r2;

    initial begin
        i_rstn = 1'b0;
        i_idle_timeout = 0; i_bit_violation = 0; i_cha_stuck = 0; i_chb_stuck = 0;
        i_cha_ismst = 0; i_chb_ismst = 0;
        i_rd_req = 0; i_rd_sel = 0; i_rd_clr = 0;
        #23;
        check("reset_ack", 32'(ack0), 32'd0);
        check("reset_data", 32'(data0), 32'd0);
        check("reset_irq", 32'(irq0), 32'd0);
        i_rstn = 1'b1;
        chk_en = 1'b1;
        cyc();

        // 1: reset in the middle of a handshake (WAIT)
        pulses(2, 0);
        i_rd_sel = 3'd0; i_rd_clr = 1'b0; i_rd_req = 1'b1;
        cyc();
        check("t1_ack", 32'(ack0), 32'd1);
        check("t1_data", 32'(data0), 32'd2);
        cyc();
        #1 i_rstn = 1'b0;
        #1;
        check("t1_rst_ack", 32'(ack0), 32'd0);
        check("t1_rst_data", 32'(data0), 32'd0);
        i_rd_req = 1'b0;
        #2 i_rstn = 1'b1;
        cyc();
        for (int s = 0; s < 6; s++) begin
            do_read(s, 1'b0, 4'b0, r0, r1, r2);
            check("t1_zero", 32'(r0), 32'd0);
        end

        // 2: bit violation count, re-read, clear-on-read
        pulses(3, 1);
        do_read(1, 1'b0, 4'b0, r0, r1, r2);
        check("t2_rd1", 32'(r0), 32'd3);
        do_read(1, 1'b0, 4'b0, r0, r1, r2);
        check("t2_rd2", 32'(r0), 32'd3);
        do_read(1, 1'b1, 4'b0, r0, r1, r2);
        check("t2_clr", 32'(r0), 32'd3);
        do_read(1, 1'b0, 4'b0, r0, r1, r2);
        check("t2_after_clr", 32'(r0), 32'd0);

        // 3: saturate vs wrap on narrow counters
        pulses(5, 0);
        do_read(0, 1'b0, 4'b0, r0, r1, r2);
        check("t3_w8", 32'(r0), 32'd5);
        check("t3_sat", 32'(r1), 32'd3);
        check("t3_wrap", 32'(r2), 32'd1);

        // 4: read-clear coinciding with an event on the same counter
        pulses(1, 2);
        do_read(2, 1'b1, 4'b0100, r0, r1, r2);
        check("t4_snap", 32'(r0), 32'd1);
        do_read(2, 1'b0, 4'b0, r0, r1, r2);
        check("t4_after", 32'(r0), 32'd1);
        check("t4_after_w2", 32'(r2), 32'd1);

        // 5: mastership grants
        i_cha_ismst = 1'b1;
        for (int k = 0; k < 100; k++) cyc();
        i_cha_ismst = 1'b0; cyc();
        i_cha_ismst = 1'b1; cyc();
        i_chb_ismst = 1'b1; cyc();
        do_read(4, 1'b0, 4'b0, r0, r1, r2);
        check("t5_sel4", 32'(r0), 32'd2);
        do_read(5, 1'b0, 4'b0, r0, r1, r2);
        check("t5_sel5", 32'(r0), 32'd1);
        do_read(6, 1'b1, 4'b0, r0, r1, r2);
        check("t5_sel6", 32'(r0), 32'd0);
        do_read(7, 1'b0, 4'b0, r0, r1, r2);
        check("t5_sel7", 32'(r0), 32'd0);

        // 6: interrupt
        do_read(0, 1'b1, 4'b0, r0, r1, r2);
        do_read(2, 1'b1, 4'b0, r0, r1, r2);
        check("t6_irq_idle", 32'(irq0), 32'd0);
        i_chb_stuck = 1'b1;
        cyc();
        check("t6_irq_set", 32'(irq0), 32'(IRQ_ON));
        do_read(3, 1'b1, 4'b0, r0, r1, r2);
        check("t6_sel3", 32'(r0), 32'd1);
        check("t6_irq_clr", 32'(irq0), 32'd0);

        // randomized traffic checked by the model every cycle
        rnd_on = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (($urandom % 8) == 0)
                do_read(int'($urandom_range(0, 7)), 1'($urandom % 2), 4'b0, r0, r1, r2);
            else
                cyc();
        end
        rnd_on = 1'b0;
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
